// File: rtl/p_shfrot_issue_if.sv
// Request, shifter-control and response bundle around the packed shift/rotate issue stage.
// Latency: none, signals only.
// Backpressure: req_valid/req_ready on the request side and rsp_valid/rsp_ready on the response side.
// Ports: req_* are inbound requests. sh_* are the controls to the combinational shifter, and sh_result is its result.
//        rsp_* are the registered responses.
interface p_shfrot_issue_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_crs1;
    logic [4:0]       req_shamt;
    logic [2:0]       req_pw;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;

    logic [31:0]      sh_crs1;
    logic [4:0]       sh_shamt;
    logic [4:0]       sh_pw;
    logic             sh_shift;
    logic             sh_rotate;
    logic             sh_left;
    logic             sh_right;
    logic [31:0]      sh_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    // Requester / shifter / response-consumer side.
    modport master (
        output req_valid, req_crs1, req_shamt, req_pw, req_op, req_tag,
        input  req_ready,
        input  sh_crs1, sh_shamt, sh_pw, sh_shift, sh_rotate, sh_left, sh_right,
        output sh_result,
        input  rsp_valid, rsp_result, rsp_err, rsp_tag,
        output rsp_ready
    );

    // Issue stage side.
    modport slave (
        input  req_valid, req_crs1, req_shamt, req_pw, req_op, req_tag,
        output req_ready,
        output sh_crs1, sh_shamt, sh_pw, sh_shift, sh_rotate, sh_left, sh_right,
        input  sh_result,
        output rsp_valid, rsp_result, rsp_err, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/p_shfrot_issue.sv
// Issue stage for the packed shift/rotate unit. It decodes requests into one-hot shifter controls and registers the result.
// Latency: 2 cycles from request accept to rsp_valid, with one op per cycle sustained.
// Backpressure: req_ready = !a_valid || !b_valid || rsp_ready. The response is held stable while it is stalled.
// Ports: g_clk and g_reset (async, active high). flush drops everything in flight.
//        bus (slave) carries the req_*, sh_* and rsp_* groups.
module p_shfrot_issue #(
    parameter int TAG_W = 4
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    p_shfrot_issue_if.slave bus
);

    // Stage A: operand register feeding the shifter.
    logic             a_valid;
    logic [31:0]      a_crs1;
    logic [4:0]       a_shamt;
    logic [4:0]       a_pw;
    logic [1:0]       a_op;
    logic             a_err;
    logic [TAG_W-1:0] a_tag;

    // Stage B: response register.
    logic             b_valid;
    logic [31:0]      b_result;
    logic             b_err;
    logic [TAG_W-1:0] b_tag;

    // Decoded request fields.
    logic [4:0]       d_pw;
    logic [4:0]       d_shamt;
    logic             d_err;

    logic             b_free;
    logic             a_adv;
    logic             req_fire;

    assign b_free   = !b_valid || bus.rsp_ready;
    assign a_adv    = a_valid && b_free;
    assign req_fire = bus.req_valid && bus.req_ready;

    assign bus.req_ready = !a_valid || b_free;

    // Width decode. The shift amount is masked to the lane index width, so a
    // shifter lane never sees an amount >= its own width. Illegal codes
    // produce no width and a zero amount, and they raise the error flag.
    always_comb begin
        d_pw    = 5'b00000;
        d_shamt = 5'd0;
        d_err   = 1'b0;
        case (bus.req_pw)
            3'd0: begin d_pw = 5'b00001; d_shamt = bus.req_shamt;                 end
            3'd1: begin d_pw = 5'b00010; d_shamt = {1'b0, bus.req_shamt[3:0]};    end
            3'd2: begin d_pw = 5'b00100; d_shamt = {2'b00, bus.req_shamt[2:0]};   end
            3'd3: begin d_pw = 5'b01000; d_shamt = {3'b000, bus.req_shamt[1:0]};  end
            3'd4: begin d_pw = 5'b10000; d_shamt = {4'b0000, bus.req_shamt[0]};   end
            default: d_err = 1'b1;
        endcase
    end

    // Flush wins over every load. Otherwise a new accept refills A, and A
    // only goes empty when its op moves to B with nothing arriving behind it.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            a_valid <= 1'b0;
            a_crs1  <= '0;
            a_shamt <= '0;
            a_pw    <= '0;
            a_op    <= '0;
            a_err   <= 1'b0;
            a_tag   <= '0;
        end else if (flush) begin
            a_valid <= 1'b0;
        end else if (req_fire) begin
            a_valid <= 1'b1;
            a_crs1  <= bus.req_crs1;
            a_shamt <= d_shamt;
            a_pw    <= d_pw;
            a_op    <= bus.req_op;
            a_err   <= d_err;
            a_tag   <= bus.req_tag;
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
    end

    // B captures the shifter output combinationally computed from A. An
    // illegal width returns zero, whatever the shifter produced.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            b_valid  <= 1'b0;
            b_result <= '0;
            b_err    <= 1'b0;
            b_tag    <= '0;
        end else if (flush) begin
            b_valid  <= 1'b0;
        end else if (a_adv) begin
            b_valid  <= 1'b1;
            b_result <= a_err ? 32'd0 : bus.sh_result;
            b_err    <= a_err;
            b_tag    <= a_tag;
        end else if (bus.rsp_ready) begin
            b_valid  <= 1'b0;
        end
    end

    // Shifter controls are gated by a_valid, so an empty stage presents all
    // zeros rather than the stale operands of the last op.
    assign bus.sh_crs1   = a_valid ? a_crs1  : 32'd0;
    assign bus.sh_shamt  = a_valid ? a_shamt : 5'd0;
    assign bus.sh_pw     = a_valid ? a_pw    : 5'd0;
    assign bus.sh_shift  = a_valid && !a_op[1];
    assign bus.sh_rotate = a_valid &&  a_op[1];
    assign bus.sh_left   = a_valid && !a_op[0];
    assign bus.sh_right  = a_valid &&  a_op[0];

    assign bus.rsp_valid  = b_valid;
    assign bus.rsp_result = b_result;
    assign bus.rsp_err    = b_err;
    assign bus.rsp_tag    = b_tag;

endmodule

// File: tb/tb_p_shfrot_issue.sv
// Bench for p_shfrot_issue. It uses directed vectors and a scoreboard queue drained by a response monitor.
// Latency: checks the 2-cycle accept-to-response timing and one-per-cycle drain after a stall.
// Backpressure: stalls with rsp_ready low, then releases; also covers flush and asynchronous reset mid-flight.
module tb_p_shfrot_issue;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] crs1;
        logic [4:0]  shamt;
        logic [2:0]  pw;
        logic [1:0]  op;
        logic [3:0]  tag;
        logic [4:0]  exp_shamt;
        logic [4:0]  exp_pw;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    logic g_clk   = 1'b0;
    logic g_reset = 1'b1;
    logic flush   = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    p_shfrot_issue_if #(.TAG_W(4)) bus ();

    p_shfrot_issue #(.TAG_W(4)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 g_clk = ~g_clk;

    // Reference packed shifter standing in for the downstream combinational unit.
    function automatic logic [31:0] pshift(input logic [31:0] x, input logic [4:0] s,
                                           input logic [4:0] pw, input logic rot, input logic right);
        logic [31:0] r;
        int w;
        r = 32'd0;
        case (pw)
            5'b00001: w = 32;
            5'b00010: w = 16;
            5'b00100: w = 8;
            5'b01000: w = 4;
            5'b10000: w = 2;
            default:  w = 0;
        endcase
        if (w != 0) begin
            for (int i = 0; i < 32; i++) begin
                int base;
                int p;
                int src;
                base = i - (i % w);
                p    = i % w;
                src  = right ? p + int'(s) : p - int'(s);
                if (rot) src = ((src % w) + w) % w;
                if (src >= 0 && src < w) r[i] = x[base + src];
            end
        end
        return r;
    endfunction

    assign bus.sh_result = pshift(bus.sh_crs1, bus.sh_shamt, bus.sh_pw, bus.sh_rotate, bus.sh_right);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] c, input logic [4:0] s, input logic [2:0] pw,
                           input logic [1:0] op, input logic [3:0] tag);
        bus.req_valid = 1'b1;
        bus.req_crs1  = c;
        bus.req_shamt = s;
        bus.req_pw    = pw;
        bus.req_op    = op;
        bus.req_tag   = tag;
    endtask

    task automatic push_exp(input logic [31:0] res, input logic err, input logic [3:0] tag);
        exp_t e;
        e.res = res;
        e.err = err;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Presents one request and returns one cycle after it is accepted (op now in A).
    task automatic send(input logic [31:0] c, input logic [4:0] s, input logic [2:0] pw,
                        input logic [1:0] op, input logic [3:0] tag,
                        input logic [31:0] res, input logic err);
        bit done;
        done = 1'b0;
        set_req(c, s, pw, op, tag);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge g_clk);
            if (bus.req_ready) begin
                if (!flush) push_exp(res, err, tag);
                done = 1'b1;
            end
            @(posedge g_clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout tag %0d: req_ready stayed 0, required 1", tag);
        end
    endtask

    // Response monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge g_clk) begin
        if (!g_reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got tag %0d, required no response", bus.rsp_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_result", bus.rsp_result, e.res);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    vec_t vecs[6];

    initial begin
        bus.req_valid = 1'b0;
        bus.req_crs1  = '0;
        bus.req_shamt = '0;
        bus.req_pw    = '0;
        bus.req_op    = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;

        //         crs1          sh  pw    op     tag  exp_sh exp_pw    exp_res        err
        vecs[0] = '{32'h80FF0102, 9,  3'd2, 2'b01, 4,   5'd1,  5'b00100, 32'h407F0001, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 7,  3'd6, 2'b00, 5,   5'd0,  5'b00000, 32'h00000000, 1'b1};
        vecs[2] = '{32'h000000B4, 3,  3'd4, 2'b11, 6,   5'd1,  5'b10000, 32'h00000078, 1'b0};
        vecs[3] = '{32'h00000003, 31, 3'd0, 2'b00, 7,   5'd31, 5'b00001, 32'h80000000, 1'b0};
        vecs[4] = '{32'h000000FF, 6,  3'd3, 2'b00, 8,   5'd2,  5'b01000, 32'h000000CC, 1'b0};
        vecs[5] = '{32'h12345678, 5,  3'd7, 2'b11, 9,   5'd0,  5'b00000, 32'h00000000, 1'b1};

        // Reset state
        repeat (2) @(posedge g_clk);
        #2;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_sh_pw", 32'(bus.sh_pw), 32'd0);
        check("rst_sh_ctrl", 32'({bus.sh_shift, bus.sh_rotate, bus.sh_left, bus.sh_right}), 32'd0);
        @(negedge g_clk);
        g_reset = 1'b0;
        tick();

        // Rotate left, 16-bit lanes, with latency check
        send(32'h1234ABCD, 5'd4, 3'd1, 2'b10, 4'd3, 32'h2341BCDA, 1'b0);
        check("t1_sh_pw", 32'(bus.sh_pw), 32'b00010);
        check("t1_sh_ctrl", 32'({bus.sh_shift, bus.sh_rotate, bus.sh_left, bus.sh_right}), 32'b0110);
        check("t1_sh_shamt", 32'(bus.sh_shamt), 32'd4);
        check("t1_sh_crs1", bus.sh_crs1, 32'h1234ABCD);
        check("t1_rsp_not_yet", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t1_rsp_valid_n2", 32'(bus.rsp_valid), 32'd1);
        tick();
        check("t1_rsp_idle", 32'(bus.rsp_valid), 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            send(vecs[i].crs1, vecs[i].shamt, vecs[i].pw, vecs[i].op, vecs[i].tag,
                 vecs[i].exp_res, vecs[i].exp_err);
            check("vec_sh_shamt", 32'(bus.sh_shamt), 32'(vecs[i].exp_shamt));
            check("vec_sh_pw", 32'(bus.sh_pw), 32'(vecs[i].exp_pw));
            check("vec_sh_ctrl", 32'({bus.sh_shift, bus.sh_rotate, bus.sh_left, bus.sh_right}),
                  32'({!vecs[i].op[1], vecs[i].op[1], !vecs[i].op[0], vecs[i].op[0]}));
            tick();
            tick();
        end

        // Backpressure: two accepts, then the stage stalls
        bus.rsp_ready = 1'b0;
        send(32'h01010101, 5'd0, 3'd0, 2'b00, 4'd1, 32'h01010101, 1'b0);
        send(32'h02020202, 5'd0, 3'd0, 2'b00, 4'd2, 32'h02020202, 1'b0);
        set_req(32'h03030303, 5'd0, 3'd0, 2'b00, 4'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge g_clk);
            check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
            check("bp_rsp_hold_tag", 32'(bus.rsp_tag), 32'd1);
            check("bp_rsp_hold_res", bus.rsp_result, 32'h01010101);
            tick();
        end
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) set_req(32'h04040404, 5'd0, 3'd0, 2'b00, 4'd4);
            if (k >= 2) bus.req_valid = 1'b0;
            @(negedge g_clk);
            check("bp_drain_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_drain_tag", 32'(bus.rsp_tag), 32'(k + 1));
            if (bus.req_valid && bus.req_ready) push_exp(bus.req_crs1, 1'b0, bus.req_tag);
            tick();
        end
        bus.req_valid = 1'b0;
        @(negedge g_clk);
        check("bp_drain_done", 32'(bus.rsp_valid), 32'd0);
        tick();

        // Flush with both stages full
        bus.rsp_ready = 1'b0;
        send(32'h55555555, 5'd1, 3'd0, 2'b00, 4'd5, 32'hAAAAAAAA, 1'b0);
        send(32'h66666666, 5'd0, 3'd0, 2'b00, 4'd6, 32'h66666666, 1'b0);
        set_req(32'h77777777, 5'd0, 3'd0, 2'b00, 4'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        sb.delete();
        @(negedge g_clk);
        check("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("flush_a_empty", 32'({bus.sh_shift, bus.sh_rotate, bus.sh_left, bus.sh_right}), 32'd0);
        check("flush_req_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.rsp_ready = 1'b1;

        // Flush on an empty pipe: request is seen as ready but dropped
        set_req(32'h0000000B, 5'd0, 3'd0, 2'b00, 4'd11);
        flush = 1'b1;
        @(negedge g_clk);
        check("flush_ready_normal", 32'(bus.req_ready), 32'd1);
        tick();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge g_clk);
        check("flush_drop_a", 32'(bus.sh_pw), 32'd0);
        tick();
        @(negedge g_clk);
        check("flush_drop_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();

        // Asynchronous reset with both stages full
        bus.rsp_ready = 1'b0;
        send(32'hDEADBEEF, 5'd0, 3'd0, 2'b00, 4'd8, 32'hDEADBEEF, 1'b0);
        send(32'hA5A5A5A5, 5'd0, 3'd0, 2'b00, 4'd9, 32'hA5A5A5A5, 1'b0);
        #2;
        g_reset = 1'b1;
        #1;
        sb.delete();
        check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_rsp_result", bus.rsp_result, 32'd0);
        check("arst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("arst_req_ready", 32'(bus.req_ready), 32'd1);
        check("arst_sh_crs1", bus.sh_crs1, 32'd0);
        check("arst_sh_ctrl", 32'({bus.sh_pw, bus.sh_shift, bus.sh_rotate, bus.sh_left, bus.sh_right}), 32'd0);
        @(negedge g_clk);
        g_reset = 1'b0;
        tick();
        bus.rsp_ready = 1'b1;
        send(32'h0F0F0F0F, 5'd4, 3'd1, 2'b10, 4'd10, 32'hF0F0F0F0, 1'b0);
        check("post_rst_not_yet", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("post_rst_valid_n2", 32'(bus.rsp_valid), 32'd1);
        tick();
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/p_shfrot_issue.md
Name: p_shfrot_issue

Overview:
- Pipelined issue/sequencing stage that sits directly upstream of the combinational packed shift/rotate unit.
- Accepts packed shift/rotate requests over a valid/ready handshake and decodes the op and pack-width fields.
- Normalises the shift amount to the lane width, then drives the shifter's one-hot control inputs from a registered operand stage.
- Captures the shifter result into an output register with its own valid/ready handshake: 2-cycle latency, full throughput.

Parameters:
- TAG_W, 4, width of the opaque request tag carried alongside each operation.

Ports:
- g_clk  in  1  clock.
- g_reset  in  1  asynchronous active-high reset.
- flush  in  1  synchronous pipeline flush; discards all in-flight ops.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_crs1  in  32  source operand.
- req_shamt  in  5  raw shift amount.
- req_pw  in  3  pack width code: 0=32, 1=16, 2=8, 3=4, 4=2; 5-7 illegal.
- req_op  in  2  op code: 00 shift left, 01 shift right, 10 rotate left, 11 rotate right.
- req_tag  in  TAG_W  request tag.
- sh_crs1  out  32  shifter operand.
- sh_shamt  out  5  normalised shift amount.
- sh_pw  out  5  one-hot pack width: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2.
- sh_shift, sh_rotate, sh_left, sh_right  out  1 each  shifter op controls.
- sh_result  in  32  combinational shifter result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted when rsp_valid && rsp_ready.
- rsp_result  out  32  operation result.
- rsp_err  out  1  illegal pack width.
- rsp_tag  out  TAG_W  tag of this response.

Behaviour:
- Stage A: operand register.
  - On an accepted request it loads crs1, tag, decoded one-hot pw, op controls, normalised shamt and the err flag.
  - a_valid is set on accept. It is cleared when A's contents move to B and no new request is accepted in the same cycle.
- Stage B: output register.
  - B loads from A when a_valid && b_free, where b_free = !b_valid || rsp_ready.
  - Loaded values: rsp_result = a_err ? 0 : sh_result; rsp_err = a_err; rsp_tag = A tag.
  - b_valid is set on that load. It is cleared when the response is accepted and no load occurs in the same cycle.
- Handshake:
  - req_ready = !a_valid || b_free, which is combinational from rsp_ready.
  - A request accepted in cycle N gives rsp_valid in cycle N+2 when there is no backpressure.
  - Back-to-back requests sustain one response per cycle.
  - A and B both advance in the same cycle when both are occupied and rsp_ready=1.
  - rsp_* are stable while rsp_valid && !rsp_ready.
- sh_* outputs come purely from stage A registers.
  - While !a_valid they are all zero: sh_pw=0 and all op controls 0.
- Op decode:
  - shift = !op[1]; rotate = op[1].
  - left = !op[0]; right = op[0].
  - Exactly one of shift/rotate and exactly one of left/right is high while a_valid.
- Shamt normalisation, masked to log2(lane width) bits:
  - pw32 → shamt[4:0]
  - pw16 → shamt[3:0]
  - pw8 → shamt[2:0]
  - pw4 → shamt[1:0]
  - pw2 → shamt[0]
  - All other bits are zeroed.
- Illegal pw (5-7):
  - The request is accepted normally and a_err=1.
  - sh_pw=0, sh_shamt=0 and op controls are still driven.
  - The response has rsp_err=1 and rsp_result=0.
- Flush:
  - On a clock edge with flush=1, a_valid and b_valid clear.
  - A request presented in the same cycle is dropped; req_ready is still computed normally.
  - Flush overrides all loads.
- Reset (asynchronous, any time including mid-operation):
  - a_valid=0, b_valid=0, all A/B data registers 0.
  - Resulting outputs: rsp_valid=0, rsp_result=0, rsp_err=0, rsp_tag=0, req_ready=1, all sh_* outputs 0.
- No state other than stage A and stage B. No operation is ever duplicated or reordered.

Test Plan:
- Rotate left, 16-bit lanes: crs1=0x1234ABCD, shamt=4, pw=1, op=10, tag=3 → two cycles later rsp_result=0x2341BCDA, rsp_tag=3, rsp_err=0; during the A cycle sh_pw=00010, sh_rotate=1, sh_left=1.
- Shift right, 8-bit lanes, shamt masking: crs1=0x80FF0102, shamt=9, pw=2, op=01 → sh_shamt=1, rsp_result=0x407F0001.
- Illegal width: pw=6, crs1=0xFFFFFFFF, op=00 → rsp_err=1, rsp_result=0, sh_pw=0.
- Backpressure: issue 4 back-to-back requests (tags 1-4) with rsp_ready=0 → req_ready drops after 2 accepts. Raise rsp_ready → tags 1,2,3,4 appear in order on consecutive cycles with no loss or duplication.
- Flush: A and B both full, assert flush one cycle with req_valid=1 → next cycle rsp_valid=0 and a_valid=0; the flushed request never produces a response.
- Reset mid-op: assert g_reset asynchronously between clock edges with both stages full → outputs go immediately to the reset values. After deassert, a new request completes normally with 2-cycle latency.
